store_buffer: RTL and testbench

Posted-write buffer between the MEM-stage load/store path and the byte-addressed data memory. Stores are accepted in one cycle, queued in a small FIFO and drained into the data memory one per cycle in program order. Loads are issued directly to the memory when safe. A load that overlaps any pending store stalls until that store has drained. The block owns the memory's single shared address port and arbitrates it between load issue and store drain.

---
 rtl/store_buffer.sv | 157 +++++++++++++++
 tb/tb_store_buffer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Posted-write store buffer in front of the byte-addressed data memory.
// Stores are queued in a small FIFO and drained one per cycle in program order.
// Loads go straight to memory unless they overlap a pending store. The block
// arbitrates the memory's single address port between load issue and drain.
// DMWR_*/DMRE_* values below mirror the ctrl_encode_def.v codes.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [1:0]    st_type,
    input  logic [AW-1:0] st_addr,
    input  logic [31:0]   st_data,
    input  logic          ld_valid,
    input  logic [2:0]    ld_type,
    input  logic [AW-1:0] ld_addr,
    output logic          ld_stall,
    output logic          sb_empty,
    output logic [1:0]    dm_wr,
    output logic [2:0]    dm_re,
    output logic [AW-1:0] dm_addr,
    output logic [31:0]   dm_din
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] DMWR_NOP = 2'b00;
    localparam logic [1:0] DMWR_SW  = 2'b01;
    localparam logic [1:0] DMWR_SH  = 2'b10;
    localparam logic [1:0] DMWR_SB  = 2'b11;

    localparam logic [2:0] DMRE_NOP = 3'b000;
    localparam logic [2:0] DMRE_LW  = 3'b001;
    localparam logic [2:0] DMRE_LH  = 3'b010;
    localparam logic [2:0] DMRE_LHU = 3'b011;

    // Access size in bytes for a store code.
    function automatic logic [2:0] st_bytes(input logic [1:0] t);
        case (t)
            DMWR_SW: st_bytes = 3'd4;
            DMWR_SH: st_bytes = 3'd2;
            default: st_bytes = 3'd1;
        endcase
    endfunction

    // Access size in bytes for a load code.
    function automatic logic [2:0] ld_bytes(input logic [2:0] t);
        case (t)
            DMRE_LW:           ld_bytes = 3'd4;
            DMRE_LH, DMRE_LHU: ld_bytes = 3'd2;
            default:           ld_bytes = 3'd1;
        endcase
    endfunction

    // Byte ranges [a, a+na) and [b, b+nb) intersect; one extra bit so ends never wrap.
    function automatic logic ranges_overlap(input logic [AW-1:0] a, input logic [2:0] na,
                                            input logic [AW-1:0] b, input logic [2:0] nb);
        logic [AW:0] a_lo, a_end, b_lo, b_end;
        a_lo  = {1'b0, a};
        b_lo  = {1'b0, b};
        a_end = a_lo + {{(AW-2){1'b0}}, na};
        b_end = b_lo + {{(AW-2){1'b0}}, nb};
        ranges_overlap = (a_lo < b_end) && (b_lo < a_end);
    endfunction

    logic [1:0]    r_type [DEPTH];
    logic [AW-1:0] r_addr [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic          w_ld_live;
    logic          w_full;
    logic          w_overlap;
    logic          w_enq;
    logic          w_drain;
    logic [PW-1:0] w_scan_idx;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_ld_live = ld_valid && (ld_type != DMRE_NOP) && !rst;
    assign st_ready  = !rst && (r_count < CW'(DEPTH));
    assign sb_empty  = rst || (r_count == '0);
    assign w_enq     = st_valid && st_ready && (st_type != DMWR_NOP);

    // Compare the live load against every occupied entry, not just the head.
    always_comb begin
        w_overlap  = 1'b0;
        w_scan_idx = r_rptr;
        for (int i = 0; i < DEPTH; i++) begin
            w_scan_idx = r_rptr + PW'(i);
            if ((CW'(i) < r_count) &&
                ranges_overlap(r_addr[w_scan_idx], st_bytes(r_type[w_scan_idx]),
                               ld_addr, ld_bytes(ld_type)))
                w_overlap = 1'b1;
        end
    end

    // Address-port arbitration: hazard drain, anti-starvation drain, load issue, idle drain.
    always_comb begin
        w_drain  = 1'b0;
        ld_stall = 1'b0;
        dm_wr    = DMWR_NOP;
        dm_re    = DMRE_NOP;
        dm_addr  = '0;
        dm_din   = '0;
        if (!rst) begin
            if (w_ld_live && (w_overlap || (w_full && st_valid))) begin
                w_drain  = 1'b1;
                ld_stall = 1'b1;
            end else if (w_ld_live) begin
                dm_re   = ld_type;
                dm_addr = ld_addr;
            end else if (r_count != '0) begin
                w_drain = 1'b1;
            end
        end
        if (w_drain) begin
            dm_wr   = r_type[r_rptr];
            dm_addr = r_addr[r_rptr];
            dm_din  = r_data[r_rptr];
        end
    end

    // FIFO control: pointers and occupancy; reset discards every pending store.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq)
                r_wptr <= r_wptr + 1'b1;
            if (w_drain)
                r_rptr <= r_rptr + 1'b1;
            case ({w_enq, w_drain})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO payload: written on enqueue only; contents are don't-care when unoccupied.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_type[r_wptr] <= st_type;
            r_addr[r_wptr] <= st_addr;
            r_data[r_wptr] <= st_data;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: byte-addressed memory model on the dm_* port,
// scoreboard queues for expected writes and expected load data.
module tb_store_buffer;

    localparam int AW    = 10;
    localparam int DEPTH = 4;

    localparam logic [1:0] WNOP = 2'b00;
    localparam logic [1:0] WSW  = 2'b01;
    localparam logic [1:0] WSH  = 2'b10;
    localparam logic [1:0] WSB  = 2'b11;
    localparam logic [2:0] RNOP = 3'b000;
    localparam logic [2:0] RLW  = 3'b001;
    localparam logic [2:0] RLH  = 3'b010;
    localparam logic [2:0] RLHU = 3'b011;
    localparam logic [2:0] RLB  = 3'b100;
    localparam logic [2:0] RLBU = 3'b101;

    logic          clk = 1'b0;
    logic          rst;
    logic          st_valid, st_ready;
    logic [1:0]    st_type;
    logic [AW-1:0] st_addr;
    logic [31:0]   st_data;
    logic          ld_valid, ld_stall, sb_empty;
    logic [2:0]    ld_type;
    logic [AW-1:0] ld_addr;
    logic [1:0]    dm_wr;
    logic [2:0]    dm_re;
    logic [AW-1:0] dm_addr;
    logic [31:0]   dm_din;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_ready(st_ready), .st_type(st_type),
        .st_addr(st_addr), .st_data(st_data),
        .ld_valid(ld_valid), .ld_type(ld_type), .ld_addr(ld_addr),
        .ld_stall(ld_stall), .sb_empty(sb_empty),
        .dm_wr(dm_wr), .dm_re(dm_re), .dm_addr(dm_addr), .dm_din(dm_din)
    );

    typedef struct packed {
        logic [1:0]    t;
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    logic [7:0] mem     [1024] = '{default: 8'h00};
    logic [7:0] sh_spec [1024] = '{default: 8'h00};
    logic [7:0] sh_comm [1024] = '{default: 8'h00};
    wr_t         wq[$];
    logic [31:0] lq[$];
    logic [31:0] rdata;

    int n_total = 0;
    int n_bad   = 0;

    logic          s_rdy, s_stall, s_empty, s_acc;
    logic [1:0]    s_wr;
    logic [2:0]    s_re;
    logic [AW-1:0] s_addr;
    logic [31:0]   s_din;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int nbytes_wr(input logic [1:0] t);
        return (t == WSW) ? 4 : (t == WSH) ? 2 : 1;
    endfunction

    function automatic logic [31:0] ext(input logic [2:0] t, input logic [7:0] b0,
                                        input logic [7:0] b1, input logic [7:0] b2,
                                        input logic [7:0] b3);
        case (t)
            RLW:     return {b3, b2, b1, b0};
            RLH:     return {{16{b1[7]}}, b1, b0};
            RLHU:    return {16'h0, b1, b0};
            RLB:     return {{24{b0[7]}}, b0};
            RLBU:    return {24'h0, b0};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] t, input logic [AW-1:0] a);
        int i;
        i = int'(a);
        return ext(t, sh_spec[i], sh_spec[i+1], sh_spec[i+2], sh_spec[i+3]);
    endfunction

    // Data memory model: commits on the rising edge, reads combinationally.
    always @(posedge clk) begin
        if (dm_wr != WNOP) begin
            for (int k = 0; k < nbytes_wr(dm_wr); k++)
                mem[int'(dm_addr) + k] <= dm_din[8*k +: 8];
        end
    end

    always_comb begin
        rdata = ext(dm_re, mem[int'(dm_addr)], mem[int'(dm_addr)+1],
                    mem[int'(dm_addr)+2], mem[int'(dm_addr)+3]);
    end

    // Scoreboard: every write and every issued load is matched against the queues.
    always @(negedge clk) begin
        wr_t e;
        if (dm_wr != WNOP) begin
            if (wq.size() == 0) begin
                chk("spurious_wr", {30'h0, dm_wr}, 32'h0);
            end else begin
                e = wq.pop_front();
                chk("wr_type", {30'h0, dm_wr}, {30'h0, e.t});
                chk("wr_addr", {22'h0, dm_addr}, {22'h0, e.a});
                chk("wr_data", dm_din, e.d);
                for (int k = 0; k < nbytes_wr(e.t); k++)
                    sh_comm[int'(e.a) + k] = e.d[8*k +: 8];
            end
        end
        if (dm_re != RNOP) begin
            chk("rd_wr_excl", {30'h0, dm_wr}, 32'h0);
            if (lq.size() == 0)
                chk("spurious_rd", {29'h0, dm_re}, 32'h0);
            else
                chk("ld_data", rdata, lq.pop_front());
        end
    end

    // One clock cycle of stimulus; samples outputs mid-cycle after the monitor.
    task automatic cyc(input logic sv, input logic [1:0] stt, input logic [AW-1:0] sa,
                       input logic [31:0] sd, input logic lv, input logic [2:0] lt,
                       input logic [AW-1:0] la, input logic lnew);
        wr_t e;
        @(posedge clk);
        #1;
        st_valid = sv; st_type = stt; st_addr = sa; st_data = sd;
        ld_valid = lv; ld_type = lt;  ld_addr = la;
        if (lnew && lv && lt != RNOP)
            lq.push_back(exp_load(lt, la));
        #5;
        s_rdy = st_ready; s_stall = ld_stall; s_empty = sb_empty;
        s_wr = dm_wr; s_re = dm_re; s_addr = dm_addr; s_din = dm_din;
        s_acc = sv && st_ready && (stt != WNOP);
        if (s_acc) begin
            e.t = stt; e.a = sa; e.d = sd;
            wq.push_back(e);
            for (int k = 0; k < nbytes_wr(stt); k++)
                sh_spec[int'(sa) + k] = sd[8*k +: 8];
        end
    endtask

    task automatic idle();
        cyc(1'b0, WNOP, '0, 32'h0, 1'b0, RNOP, '0, 1'b0);
    endtask

    // Present a load and hold it until it issues; checks the number of stall cycles.
    task automatic do_load(input string tag, input logic [2:0] lt, input logic [AW-1:0] la,
                           input int exp_stall);
        int  n;
        bit  done;
        n = 0;
        done = 0;
        cyc(1'b0, WNOP, '0, 32'h0, 1'b1, lt, la, 1'b1);
        for (int k = 0; k < 20 && !done; k++) begin
            if (s_stall) begin
                n++;
                cyc(1'b0, WNOP, '0, 32'h0, 1'b1, lt, la, 1'b0);
            end else begin
                done = 1;
            end
        end
        chk({tag, "_stalls"}, n, exp_stall);
    endtask

    // One reset cycle with traffic present, then the first cycle after it.
    task automatic rst_pulse(input string tag);
        @(posedge clk);
        #1;
        rst = 1'b1;
        st_valid = 1'b1; st_type = WSW; st_addr = 10'h080; st_data = 32'h77777777;
        ld_valid = 1'b1; ld_type = RLW; ld_addr = 10'h080;
        #5;
        chk({tag, "_in_rdy"},   {31'h0, st_ready}, 32'h0);
        chk({tag, "_in_stall"}, {31'h0, ld_stall}, 32'h0);
        chk({tag, "_in_empty"}, {31'h0, sb_empty}, 32'h1);
        chk({tag, "_in_wr"},    {30'h0, dm_wr},    32'h0);
        chk({tag, "_in_re"},    {29'h0, dm_re},    32'h0);
        chk({tag, "_in_addr"},  {22'h0, dm_addr},  32'h0);
        chk({tag, "_in_din"},   dm_din,            32'h0);
        wq.delete();
        sh_spec = sh_comm;
        @(posedge clk);
        #1;
        rst = 1'b0;
        st_valid = 1'b0; st_type = WNOP; st_addr = '0; st_data = '0;
        ld_valid = 1'b0; ld_type = RNOP; ld_addr = '0;
        #5;
        chk({tag, "_post_rdy"},   {31'h0, st_ready}, 32'h1);
        chk({tag, "_post_empty"}, {31'h0, sb_empty}, 32'h1);
        chk({tag, "_post_wr"},    {30'h0, dm_wr},    32'h0);
        chk({tag, "_post_stall"}, {31'h0, ld_stall}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        st_valid = 1'b0; st_type = WNOP; st_addr = '0; st_data = '0;
        ld_valid = 1'b0; ld_type = RNOP; ld_addr = '0;

        rst_pulse("init");

        // Single word store, drained with no loads around.
        cyc(1'b1, WSW, 10'h010, 32'hDEADBEEF, 1'b0, RNOP, '0, 1'b0);
        chk("t1_rdy", {31'h0, s_rdy}, 32'h1);
        idle();
        chk("t1_wr",   {30'h0, s_wr},   {30'h0, WSW});
        chk("t1_addr", {22'h0, s_addr}, 32'h010);
        chk("t1_din",  s_din,           32'hDEADBEEF);
        idle();
        chk("t1_empty", {31'h0, s_empty}, 32'h1);
        do_load("t1_lw", RLW, 10'h010, 0);

        // Byte store followed by an overlapping and a non-overlapping load.
        cyc(1'b1, WSB, 10'h013, 32'h000000A5, 1'b0, RNOP, '0, 1'b0);
        do_load("t2_lbu", RLBU, 10'h013, 1);
        cyc(1'b1, WSB, 10'h013, 32'h0000005A, 1'b0, RNOP, '0, 1'b0);
        do_load("t2_lw", RLW, 10'h014, 0);
        idle();
        chk("t2_drain", {30'h0, s_wr}, {30'h0, WSB});
        do_load("t2_lb", RLB, 10'h013, 0);

        // Three halfword stores queued behind unrelated loads, then a hazard on the last.
        cyc(1'b1, WSH, 10'h020, 32'h00001111, 1'b1, RLW, 10'h100, 1'b1);
        cyc(1'b1, WSH, 10'h030, 32'h00002222, 1'b1, RLW, 10'h104, 1'b1);
        cyc(1'b1, WSH, 10'h040, 32'h0000B333, 1'b1, RLW, 10'h108, 1'b1);
        do_load("t3_lw", RLW, 10'h040, 3);
        idle();
        chk("t3_empty", {31'h0, s_empty}, 32'h1);
        do_load("t3_lh", RLH, 10'h040, 0);

        // Fill the buffer under continuous loads, then force a drain.
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b1, WSW, AW'(10'h300 + 4*i), 32'hCAFE0000 + i, 1'b1, RLW, AW'(10'h200 + 4*i), 1'b1);
            chk("t4_fill_rdy",   {31'h0, s_rdy},   32'h1);
            chk("t4_fill_stall", {31'h0, s_stall}, 32'h0);
        end
        cyc(1'b1, WSW, 10'h310, 32'hCAFE0004, 1'b1, RLW, 10'h210, 1'b1);
        chk("t4_full_rdy",   {31'h0, s_rdy},   32'h0);
        chk("t4_full_stall", {31'h0, s_stall}, 32'h1);
        chk("t4_full_wr",    {30'h0, s_wr},    {30'h0, WSW});
        chk("t4_full_addr",  {22'h0, s_addr},  32'h300);
        cyc(1'b1, WSW, 10'h310, 32'hCAFE0004, 1'b1, RLW, 10'h210, 1'b0);
        chk("t4_after_rdy",   {31'h0, s_rdy},   32'h1);
        chk("t4_after_stall", {31'h0, s_stall}, 32'h0);
        for (int i = 0; i < DEPTH + 2; i++) idle();
        chk("t4_empty", {31'h0, s_empty}, 32'h1);
        do_load("t4_lw", RLW, 10'h30C, 0);

        // Reset while stores are pending: they must never reach memory.
        cyc(1'b1, WSW, 10'h080, 32'h11111111, 1'b1, RLW, 10'h180, 1'b1);
        cyc(1'b1, WSW, 10'h084, 32'h22222222, 1'b1, RLW, 10'h184, 1'b1);
        cyc(1'b1, WSW, 10'h088, 32'h33333333, 1'b1, RLW, 10'h188, 1'b1);
        chk("t5_pending", {31'h0, s_empty}, 32'h0);
        rst_pulse("t5_rst");
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("t5_no_wr", {30'h0, s_wr}, 32'h0);
        end
        do_load("t5_lw0", RLW, 10'h080, 0);
        do_load("t5_lw1", RLW, 10'h084, 0);
        do_load("t5_lw2", RLW, 10'h088, 0);

        // A NOP-typed store request is ignored.
        cyc(1'b1, WNOP, 10'h050, 32'h12345678, 1'b0, RNOP, '0, 1'b0);
        chk("t6_empty_now", {31'h0, s_empty}, 32'h1);
        idle();
        chk("t6_empty_next", {31'h0, s_empty}, 32'h1);
        chk("t6_no_wr",      {30'h0, s_wr},    32'h0);
        do_load("t6_lw", RLW, 10'h050, 0);

        idle();
        idle();
        chk("wq_drained", wq.size(), 32'h0);
        chk("lq_drained", lq.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
